fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
//
// PURPOSE
// - Shares the single write port of the synchronous FIFO among N_REQ requesters.
// - Each requester uses a valid/ready interface.
// - Arbitration is round-robin with burst hold: a winner keeps the port until it
//   sends last, reaches BURST_MAX beats, or drops valid.
// - Sits directly in front of the FIFO: drives its write enable and write data, and
//   throttles on the FIFO's full and almost-full flags.
//
// PARAMETERS
// - N_REQ      4    number of requesters (2..16)
// - DATA_W     128  data width; must match the FIFO DATA_W
// - BURST_MAX  4    maximum beats per grant (1..255)
//
// PORTS
// - clk            in   1             clock, rising edge
// - rstn           in   1             reset, asynchronous, active-low
// - i_req_valid    in   N_REQ         per-requester beat valid
// - i_req_data     in   N_REQ*DATA_W  requester k data in bits [k*DATA_W +: DATA_W]
// - i_req_last     in   N_REQ         per-requester last beat of burst
// - o_req_ready    out  N_REQ         per-requester beat accepted when valid&ready
// - o_grant        out  N_REQ         one-hot current owner; all-zero when idle
// - o_fifo_wren    out  1             FIFO write enable
// - o_fifo_wrdata  out  DATA_W        FIFO write data
// - i_fifo_full    in   1             FIFO full flag
// - i_fifo_alm_full in  1             FIFO almost-full flag
//
// BEHAVIOUR
// - Reset (rstn=0, async): state=IDLE, o_grant=0, beat_cnt=0, last_ptr=N_REQ-1.
//   - Requester 0 therefore has first priority.
//   - o_req_ready=0, o_fifo_wren=0, o_fifo_wrdata=0 while in reset.
//   - Reset mid-burst aborts the burst. Beats already written stay in the FIFO.
// - FSM IDLE -> BURST:
//   - Condition: |i_req_valid && !i_fifo_alm_full.
//   - Winner = first valid requester scanning last_ptr+1, last_ptr+2, ... with
//     wrap-around modulo N_REQ.
//   - o_grant is registered: it is set one cycle after valid is seen in IDLE,
//     so arbitration latency is 1 cycle.
//   - If i_fifo_alm_full=1, no new grant is issued and the FSM stays in IDLE.
// - In BURST (owner g):
//   - o_req_ready[g] = !i_fifo_full; all other ready bits are 0.
//   - Ready does not depend on valid.
//   - beat = i_req_valid[g] && o_req_ready[g].
//   - o_fifo_wren = beat (combinational).
//   - o_fifo_wrdata = data of g in BURST, 0 in IDLE.
//   - Each beat increments beat_cnt.
//   - i_fifo_alm_full is ignored mid-burst; i_fifo_full stalls with no beat and no
//     count change.
// - BURST -> IDLE, on the clock edge after any of these:
//   - a beat with i_req_last[g]=1;
//   - a beat that makes beat_cnt == BURST_MAX;
//   - i_req_valid[g]=0 with no beat (owner idle).
//   - On exit: last_ptr<=g, beat_cnt<=0, o_grant<=0.
//   - The IDLE cycle is mandatory, so there are no back-to-back grants and each new
//     burst has a 1-cycle bubble.
// - Fairness: after serving g, g has lowest priority. Any continuously valid
//   requester is granted within N_REQ-1 bursts.
// - Arithmetic:
//   - beat_cnt is $clog2(BURST_MAX+1) bits and never exceeds BURST_MAX.
//   - last_ptr is $clog2(N_REQ) bits (minimum 1) and wraps from N_REQ-1 to 0.
// - Invariants:
//   - o_grant is always one-hot or zero.
//   - o_fifo_wren=1 never occurs while i_fifo_full=1.
//   - At most one o_req_ready bit is high.
//
// CONFIGURATION
// - ARB_STRICT_PRIO_EN defined:
//   - Fixed priority; lowest index valid requester wins in IDLE.
//   - last_ptr is not used.
//   - Burst hold and all exit rules are unchanged.
// - Not defined (default): round-robin as described above.
//
// TESTING
// - Reset, then all 4 valid with last=1 every beat:
//   - grants go 0,1,2,3,0.
//   - one beat per grant, with an IDLE cycle between grants.
// - Req1 sends 6 beats, last only on the 6th, BURST_MAX=4:
//   - 4 beats, then release;
//   - req1 is re-granted after the other valid requesters;
//   - the remaining 2 beats complete.
// - i_fifo_full=1 for 3 cycles mid-burst:
//   - o_req_ready[g]=0 and o_fifo_wren=0 for those 3 cycles;
//   - beat_cnt is held;
//   - the burst resumes with no data loss and no duplication.
// - i_fifo_alm_full=1 in IDLE with req2 valid:
//   - no grant while the flag is high;
//   - grant 2 is issued the cycle after the flag drops.
// - rstn=0 asynchronously after beat 2 of a burst:
//   - all outputs are 0 immediately;
//   - after release, requester 0 has priority.
// - With ARB_STRICT_PRIO_EN, req0 and req3 continuously valid:
//   - req0 is always granted; req3 is never granted.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-hold arbiter for the FIFO write port
// Optional: ARB_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 128,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_fifo_wren,
  output logic [DATA_W-1:0]       o_fifo_wrdata,
  input  logic                    i_fifo_full,
  input  logic                    i_fifo_alm_full
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant, grant_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic [PTR_W-1:0] win;
  logic             win_ok;
  logic             beat;
  logic             release_now;
`ifndef ARB_STRICT_PRIO_EN
  logic [PTR_W-1:0] last_ptr, last_ptr_nxt;
  int               idx;
`endif

  // Scan runs from farthest to nearest candidate so the nearest valid one wins.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
`ifdef ARB_STRICT_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        win    = PTR_W'(i);
        win_ok = 1'b1;
      end
    end
`else
    idx = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last_ptr) + i) % N_REQ;
      if (i_req_valid[PTR_W'(idx)]) begin
        win    = PTR_W'(idx);
        win_ok = 1'b1;
      end
    end
`endif
  end

  assign o_grant       = grant;
  assign o_req_ready   = (state == BURST && !i_fifo_full) ? grant : '0;
  assign beat          = |(i_req_valid & o_req_ready);
  assign o_fifo_wren   = beat;
  assign o_fifo_wrdata = (state == BURST) ? i_req_data[int'(owner)*DATA_W +: DATA_W] : '0;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    owner_nxt    = owner;
    cnt_nxt      = beat_cnt;
    release_now  = 1'b0;
`ifndef ARB_STRICT_PRIO_EN
    last_ptr_nxt = last_ptr;
`endif
    case (state)
      IDLE: begin
        if (win_ok && !i_fifo_alm_full) begin
          state_nxt = BURST;
          owner_nxt = win;
          grant_nxt = N_REQ'(1) << win;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (beat) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
          if (i_req_last[owner] || cnt_nxt == CNT_W'(BURST_MAX)) release_now = 1'b1;
        end else if (!i_req_valid[owner]) begin
          release_now = 1'b1;
        end
        if (release_now) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          cnt_nxt   = '0;
`ifndef ARB_STRICT_PRIO_EN
          last_ptr_nxt = owner;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      beat_cnt <= '0;
`ifndef ARB_STRICT_PRIO_EN
      last_ptr <= PTR_W'(N_REQ - 1);
`endif
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      owner    <= owner_nxt;
      beat_cnt <= cnt_nxt;
`ifndef ARB_STRICT_PRIO_EN
      last_ptr <= last_ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int BM = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    vld, lst, rdy, gnt;
  logic [N*DW-1:0] dat;
  logic            wren, full, alm;
  logic [DW-1:0]   wdata;

  int n_cmp = 0;
  int n_bad = 0;

  int seq [N];
  int tot [N];
  int blen[N];
  logic [DW-1:0] wq[$];
  int            gq[$];
  logic [N-1:0]  prev_grant;
  int            busy;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .rstn(rstn),
    .i_req_valid(vld), .i_req_data(dat), .i_req_last(lst),
    .o_req_ready(rdy), .o_grant(gnt),
    .o_fifo_wren(wren), .o_fifo_wrdata(wdata),
    .i_fifo_full(full), .i_fifo_alm_full(alm)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int k, input int s);
    logic [7:0] tag;
    tag = 8'hA0 + 8'(k);
    return {tag, 104'h0, 8'(k), 8'(s)};
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (seq[k] < tot[k]) begin
        vld[k] = 1'b1;
        dat[k*DW +: DW] = mk(k, seq[k]);
        lst[k] = ((seq[k] + 1) % blen[k]) == 0;
      end else begin
        vld[k] = 1'b0;
        dat[k*DW +: DW] = '0;
        lst[k] = 1'b0;
      end
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      seq[k] = 0; tot[k] = 0; blen[k] = 1;
    end
    wq.delete();
    gq.delete();
    busy = 0;
    drive();
  endtask

  function automatic bit model_done();
    for (int k = 0; k < N; k++) if (seq[k] < tot[k]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: observe at negedge, advance requesters just after posedge.
  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = vld & rdy;
    n_cmp++;
    if (((gnt & (gnt - 1'b1)) != 0) || (wren && full) || ((rdy & (rdy - 1'b1)) != 0)) begin
      n_bad++;
      $display("FAIL invariant grant=%b ready=%b wren=%b full=%b", gnt, rdy, wren, full);
    end
    if (wren) wq.push_back(wdata);
    if (gnt != 0) busy++;
    if (gnt != 0 && prev_grant == 0)
      for (int k = 0; k < N; k++) if (gnt[k]) gq.push_back(k);
    prev_grant = gnt;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) if (acc[k]) seq[k]++;
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (model_done() && prev_grant == 0) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL idle_timeout budget=%0d exceeded", budget); end
  endtask

  task automatic test_reset();
    rstn = 1'b0; full = 1'b0; alm = 1'b0; prev_grant = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (gnt !== 4'b0 || rdy !== 4'b0 || wren !== 1'b0 || wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs grant=%b ready=%b wren=%b data=%h want all zero", gnt, rdy, wren, wdata);
    end
    rstn = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int exp_s[5] = '{0, 0, 0, 0, 1};
    clear_model();
    tot = '{2, 1, 1, 1};
    lst = '1;
    drive();
    run_until_idle(40);
    n_cmp++;
    if (gq.size() !== 5) begin n_bad++; $display("FAIL rr_grant_count got %0d want 5", gq.size()); end
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      n_cmp++;
      if (gq[i] !== exp_g[i]) begin n_bad++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, gq[i], exp_g[i]); end
    end
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== mk(exp_g[i], exp_s[i])) begin
        n_bad++; $display("FAIL rr_data[%0d] got %h want %h", i, wq[i], mk(exp_g[i], exp_s[i]));
      end
    end
    n_cmp++;
    if (busy !== 5) begin n_bad++; $display("FAIL rr_busy_cycles got %0d want 5", busy); end
  endtask

  task automatic test_burst_max();
    int exp_g[4] = '{1, 3, 0, 1};
    int exp_k[8] = '{1, 1, 1, 1, 3, 0, 1, 1};
    int exp_s[8] = '{0, 1, 2, 3, 0, 0, 4, 5};
    clear_model();
    tot = '{1, 6, 0, 1};
    blen = '{1, 6, 1, 1};
    drive();
    run_until_idle(60);
    n_cmp++;
    if (gq.size() !== 4 || wq.size() !== 8) begin
      n_bad++; $display("FAIL bm_counts grants=%0d beats=%0d want 4 and 8", gq.size(), wq.size());
    end
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      n_cmp++;
      if (gq[i] !== exp_g[i]) begin n_bad++; $display("FAIL bm_grant[%0d] got %0d want %0d", i, gq[i], exp_g[i]); end
    end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== mk(exp_k[i], exp_s[i])) begin
        n_bad++; $display("FAIL bm_data[%0d] got %h want %h", i, wq[i], mk(exp_k[i], exp_s[i]));
      end
    end
    n_cmp++;
    if (busy !== 8) begin n_bad++; $display("FAIL bm_busy_cycles got %0d want 8", busy); end
  endtask

  task automatic test_fifo_full();
    int guard = 0;
    clear_model();
    tot[2] = 4; blen[2] = 4;
    drive();
    while (wq.size() < 2 && guard < 20) begin cycle(); guard++; end
    n_cmp++;
    if (wq.size() !== 2) begin n_bad++; $display("FAIL full_prefix beats=%0d want 2", wq.size()); end
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy !== 4'b0 || wren !== 1'b0 || gnt !== 4'b0100) begin
        n_bad++; $display("FAIL full_stall[%0d] ready=%b wren=%b grant=%b want 0000 0 0100", c, rdy, wren, gnt);
      end
      @(posedge clk); #1;
    end
    full = 1'b0;
    run_until_idle(20);
    n_cmp++;
    if (gq.size() !== 1 || wq.size() !== 4) begin
      n_bad++; $display("FAIL full_counts grants=%0d beats=%0d want 1 and 4", gq.size(), wq.size());
    end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== mk(2, i)) begin n_bad++; $display("FAIL full_data[%0d] got %h want %h", i, wq[i], mk(2, i)); end
    end
  endtask

  task automatic test_alm_full();
    clear_model();
    alm = 1'b1;
    tot[2] = 1;
    drive();
    repeat (3) cycle();
    n_cmp++;
    if (gq.size() !== 0 || prev_grant !== 4'b0) begin
      n_bad++; $display("FAIL alm_no_grant grants=%0d grant=%b want 0", gq.size(), prev_grant);
    end
    alm = 1'b0;
    cycle();
    n_cmp++;
    if (gq.size() !== 0) begin n_bad++; $display("FAIL alm_drop_cycle grants=%0d want 0", gq.size()); end
    cycle();
    n_cmp++;
    if (gq.size() !== 1 || prev_grant !== 4'b0100) begin
      n_bad++; $display("FAIL alm_grant grants=%0d grant=%b want 1 0100", gq.size(), prev_grant);
    end
    run_until_idle(20);
  endtask

  task automatic test_reset_mid_burst();
    int guard = 0;
    clear_model();
    tot[0] = 4; blen[0] = 4;
    drive();
    while (wq.size() < 2 && guard < 20) begin cycle(); guard++; end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0 || rdy !== 4'b0 || wren !== 1'b0 || wdata !== '0) begin
      n_bad++; $display("FAIL rst_mid_async grant=%b ready=%b wren=%b data=%h want all zero", gnt, rdy, wren, wdata);
    end
    clear_model();
    tot[0] = 1; tot[3] = 1;
    drive();
    @(posedge clk); #1;
    n_cmp++;
    if (gnt !== 4'b0 || rdy !== 4'b0 || wren !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_held grant=%b ready=%b wren=%b want zero", gnt, rdy, wren);
    end
    rstn = 1'b1;
    prev_grant = '0;
    run_until_idle(30);
    n_cmp++;
    if (gq.size() !== 2 || gq[0] !== 0) begin
      n_bad++; $display("FAIL rst_priority first_grant=%0d count=%0d want 0 and 2", gq.size() > 0 ? gq[0] : -1, gq.size());
    end
  endtask

`ifdef ARB_STRICT_PRIO_EN
  task automatic test_strict();
    clear_model();
    tot[0] = 8; tot[3] = 8;
    drive();
    repeat (14) cycle();
    n_cmp++;
    if (gq.size() == 0) begin n_bad++; $display("FAIL strict_any_grant got 0 grants"); end
    for (int i = 0; i < gq.size(); i++) begin
      n_cmp++;
      if (gq[i] !== 0) begin n_bad++; $display("FAIL strict_grant[%0d] got %0d want 0", i, gq[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ARB_STRICT_PRIO_EN
    test_strict();
`else
    test_round_robin();
    test_burst_max();
    test_fifo_full();
    test_alm_full();
    test_reset_mid_burst();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
